// File: rtl/key_conditioner_if.sv
// Key bundle between the board pins and the key conditioner.
// The master side drives the raw keys; the slave side returns the conditioned events.
interface key_conditioner_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_down;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_hold;

  modport master (
    output key_n,
    input  key_down,
    input  key_press,
    input  key_release,
    input  key_hold
  );

  modport slave (
    input  key_n,
    output key_down,
    output key_press,
    output key_release,
    output key_hold
  );
endinterface

// File: rtl/key_conditioner.sv
// Turns raw active-low bouncing push-buttons into clean active-high level, press,
// release and one-shot long-press events, one independent channel per key.
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input logic              clk,
  input logic              nrst,
  key_conditioner_if.slave bus
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HCW = $clog2(HOLD_CYCLES) + 1;

  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ARM_PRESS   = 2'd1;
  localparam logic [1:0] ST_DOWN        = 2'd2;
  localparam logic [1:0] ST_ARM_RELEASE = 2'd3;

  logic [N_KEYS-1:0] sync1_r;
  logic [N_KEYS-1:0] sync2_r;
  logic [N_KEYS-1:0] key_s;

  logic [1:0]     state_r    [N_KEYS];
  logic [1:0]     state_s    [N_KEYS];
  logic [DCW-1:0] deb_cnt_r  [N_KEYS];
  logic [DCW-1:0] deb_cnt_s  [N_KEYS];
  logic [HCW-1:0] hold_cnt_r [N_KEYS];
  logic [HCW-1:0] hold_cnt_s [N_KEYS];

  logic [N_KEYS-1:0] down_s;
  logic [N_KEYS-1:0] hold_s;
  logic [N_KEYS-1:0] down_r;
  logic [N_KEYS-1:0] press_r;
  logic [N_KEYS-1:0] release_r;
  logic [N_KEYS-1:0] hold_r;

  assign key_s = ~sync2_r;

  // Next-state logic for the debounce FSM and the long-press counter of every key.
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      state_s[k]    = state_r[k];
      deb_cnt_s[k]  = deb_cnt_r[k];
      hold_cnt_s[k] = hold_cnt_r[k];
      hold_s[k]     = 1'b0;

      case (state_r[k])
        ST_IDLE: begin
          if (key_s[k]) begin
            state_s[k]   = ST_ARM_PRESS;
            deb_cnt_s[k] = DCW'(1);
          end else begin
            deb_cnt_s[k] = DCW'(0);
          end
        end
        ST_ARM_PRESS: begin
          if (!key_s[k]) begin
            state_s[k]   = ST_IDLE;
            deb_cnt_s[k] = DCW'(0);
          end else if (deb_cnt_r[k] == DEB_LAST) begin
            state_s[k]   = ST_DOWN;
            deb_cnt_s[k] = DCW'(0);
          end else begin
            deb_cnt_s[k] = deb_cnt_r[k] + DCW'(1);
          end
        end
        ST_DOWN: begin
          if (!key_s[k]) begin
            state_s[k]   = ST_ARM_RELEASE;
            deb_cnt_s[k] = DCW'(1);
          end else begin
            deb_cnt_s[k] = DCW'(0);
          end
        end
        ST_ARM_RELEASE: begin
          if (key_s[k]) begin
            state_s[k]   = ST_DOWN;
            deb_cnt_s[k] = DCW'(0);
          end else if (deb_cnt_r[k] == DEB_LAST) begin
            state_s[k]   = ST_IDLE;
            deb_cnt_s[k] = DCW'(0);
          end else begin
            deb_cnt_s[k] = deb_cnt_r[k] + DCW'(1);
          end
        end
        default: begin
          state_s[k]   = ST_IDLE;
          deb_cnt_s[k] = DCW'(0);
        end
      endcase

      down_s[k] = (state_s[k] == ST_DOWN) || (state_s[k] == ST_ARM_RELEASE);

      // The hold count follows the registered level, so a release on the threshold cycle still fires hold.
      if (down_r[k]) begin
        if (hold_cnt_r[k] != HOLD_LAST) begin
          hold_cnt_s[k] = hold_cnt_r[k] + HCW'(1);
          hold_s[k]     = ((hold_cnt_r[k] + HCW'(1)) == HOLD_LAST);
        end else begin
          hold_cnt_s[k] = hold_cnt_r[k];
          hold_s[k]     = 1'b0;
        end
      end else begin
        hold_cnt_s[k] = HCW'(0);
        hold_s[k]     = 1'b0;
      end
    end
  end

  // Synchronisers, FSM state, counters and registered event outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1_r   <= {N_KEYS{1'b1}};
      sync2_r   <= {N_KEYS{1'b1}};
      down_r    <= {N_KEYS{1'b0}};
      press_r   <= {N_KEYS{1'b0}};
      release_r <= {N_KEYS{1'b0}};
      hold_r    <= {N_KEYS{1'b0}};
      for (int k = 0; k < N_KEYS; k++) begin
        state_r[k]    <= ST_IDLE;
        deb_cnt_r[k]  <= DCW'(0);
        hold_cnt_r[k] <= HCW'(0);
      end
    end else begin
      sync1_r   <= bus.key_n;
      sync2_r   <= sync1_r;
      down_r    <= down_s;
      press_r   <= down_s & ~down_r;
      release_r <= ~down_s & down_r;
      hold_r    <= hold_s;
      for (int k = 0; k < N_KEYS; k++) begin
        state_r[k]    <= state_s[k];
        deb_cnt_r[k]  <= deb_cnt_s[k];
        hold_cnt_r[k] <= hold_cnt_s[k];
      end
    end
  end

  assign bus.key_down    = down_r;
  assign bus.key_press   = press_r;
  assign bus.key_release = release_r;
  assign bus.key_hold    = hold_r;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected pulse events,
// a negedge monitor pops and compares them whenever the DUT emits a pulse.
module tb_key_conditioner;

  localparam int NK   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int LAT  = 6;   // DEB + 2: synchroniser plus debounce window

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] hold;
    logic [1:0] down;
  } ev_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];

  key_conditioner_if #(.N_KEYS(NK)) bus ();

  key_conditioner #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic expect_ev(input int c, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] h, input logic [1:0] d);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    e.hold  = h;
    e.down  = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_quiet(input string name);
    checks++;
    if (bus.key_down !== 2'b00 || bus.key_press !== 2'b00 ||
        bus.key_release !== 2'b00 || bus.key_hold !== 2'b00) begin
      errors++;
      $display("FAIL %s: cycle %0d got down=%b press=%b release=%b hold=%b, required all 00",
               name, cyc, bus.key_down, bus.key_press, bus.key_release, bus.key_hold);
    end
  endtask

  // Monitor: every pulse cycle must match the head of the expectation queue.
  always @(negedge clk) begin
    ev_t e;
    if ((|{bus.key_press, bus.key_release, bus.key_hold}) === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cycle %0d got press=%b release=%b hold=%b down=%b, required no pulse",
                 cyc, bus.key_press, bus.key_release, bus.key_hold, bus.key_down);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || bus.key_press !== e.press || bus.key_release !== e.rel ||
            bus.key_hold !== e.hold || bus.key_down !== e.down) begin
          errors++;
          $display("FAIL event: got cycle %0d press=%b release=%b hold=%b down=%b, required cycle %0d press=%b release=%b hold=%b down=%b",
                   cyc, bus.key_press, bus.key_release, bus.key_hold, bus.key_down,
                   e.cyc, e.press, e.rel, e.hold, e.down);
        end
      end
    end
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event: no pulse seen, required cycle %0d press=%b release=%b hold=%b down=%b",
               exp_q[0].cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].hold, exp_q[0].down);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    int e0;
    int r0;
    int p0;
    int f2;
    int fr;

    // Reset with keys released, then idle.
    bus.key_n = 2'b11;
    nrst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet("reset_quiet");
    end
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_quiet("idle_quiet");
    end

    // Clean press of key 0, single hold pulse, then release.
    e0 = cyc + 1;
    bus.key_n[0] = 1'b0;
    expect_ev(e0 + LAT,        2'b01, 2'b00, 2'b00, 2'b01);
    expect_ev(e0 + LAT + HOLD, 2'b00, 2'b00, 2'b01, 2'b01);
    wait_until(e0 + LAT + 20);
    r0 = cyc + 1;
    bus.key_n[0] = 1'b1;
    expect_ev(r0 + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_until(r0 + LAT + 3);

    // Bounced press: 3 low, 1 high, then low held; release lands on the hold threshold.
    bus.key_n[0] = 1'b0;
    step(3);
    bus.key_n[0] = 1'b1;
    step(1);
    f2 = cyc + 1;
    bus.key_n[0] = 1'b0;
    p0 = f2 + LAT;
    expect_ev(p0, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_until(p0 + 3);
    bus.key_n[0] = 1'b1;
    expect_ev(p0 + HOLD, 2'b00, 2'b01, 2'b01, 2'b00);
    wait_until(p0 + HOLD + 3);

    // Both keys together; key 1 released with a 2-cycle bounce.
    e0 = cyc + 1;
    bus.key_n = 2'b00;
    p0 = e0 + LAT;
    expect_ev(p0,        2'b11, 2'b00, 2'b00, 2'b11);
    expect_ev(p0 + HOLD, 2'b00, 2'b00, 2'b11, 2'b11);
    wait_until(p0 + 2);
    bus.key_n[1] = 1'b1;
    step(1);
    bus.key_n[1] = 1'b0;
    step(2);
    fr = cyc + 1;
    bus.key_n[1] = 1'b1;
    expect_ev(fr + LAT, 2'b00, 2'b10, 2'b00, 2'b01);
    wait_until(fr + LAT + 3);

    // Reset pulse while key 0 stays held: treated as a fresh press, no release.
    nrst = 1'b0;
    @(negedge clk);
    chk_quiet("midrun_reset_quiet");
    @(negedge clk);
    chk_quiet("midrun_reset_quiet");
    nrst = 1'b1;
    e0 = cyc + 1;
    expect_ev(e0 + LAT,        2'b01, 2'b00, 2'b00, 2'b01);
    expect_ev(e0 + LAT + HOLD, 2'b00, 2'b00, 2'b01, 2'b01);
    wait_until(e0 + LAT + HOLD + 3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending events, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
